// File: rtl/qracc_mac_sched.sv
// rtl/qracc_mac_sched.sv - shares the seq_acc SRAM/MAC port between a host port and a MAC job stream
// Round-robin arbitration, settle/plane sequencing and a plane-result FIFO with valid/ready.
module qracc_mac_sched #(
  parameter int NUM_ROWS      = 128,
  parameter int NUM_COLS      = 32,
  parameter int NUM_ADC_BITS  = 4,
  parameter int NUM_CFG_BITS  = 8,
  parameter int X_BITS        = 2,
  parameter int SETTLE_CYCLES = 5,
  parameter int RES_DEPTH     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CFG_BITS-1:0]          n_input_bits_cfg,
  input  logic                             h_rq_valid_i,
  output logic                             h_rq_ready_o,
  input  logic                             h_rq_wr_i,
  input  logic [$clog2(NUM_ROWS)-1:0]      h_addr_i,
  input  logic [NUM_COLS-1:0]              h_wr_data_i,
  output logic                             h_rd_valid_o,
  output logic [NUM_COLS-1:0]              h_rd_data_o,
  input  logic                             x_valid_i,
  output logic                             x_ready_o,
  input  logic [NUM_ROWS*X_BITS-1:0]       x_data_i,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [NUM_COLS*NUM_ADC_BITS-1:0] res_data_o,
  output logic                             res_last_o,
  output logic                             acc_rq_valid_o,
  output logic                             acc_rq_wr_o,
  output logic [$clog2(NUM_ROWS)-1:0]      acc_addr_o,
  output logic [NUM_COLS-1:0]              acc_wr_data_o,
  input  logic                             acc_rq_ready_i,
  input  logic                             acc_rd_valid_i,
  input  logic [NUM_COLS-1:0]              acc_rd_data_i,
  output logic                             acc_mac_en_o,
  output logic [NUM_ROWS*X_BITS-1:0]       acc_x_data_o,
  input  logic [NUM_COLS*NUM_ADC_BITS-1:0] acc_adc_out_i,
  output logic                             busy_o
);

  localparam int AW    = $clog2(NUM_ROWS);
  localparam int XW    = NUM_ROWS * X_BITS;
  localparam int RW    = NUM_COLS * NUM_ADC_BITS;
  localparam int CW    = $clog2(RES_DEPTH + 1);
  localparam int PW    = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SRAM_REQ, ST_SRAM_RD_WAIT, ST_MAC_SETTLE, ST_MAC_RUN, ST_MAC_READY
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CW-1:0]     n_q, n_eff;
  logic              rr_host_q;
  logic              acc_rq_wr_q;
  logic [AW-1:0]     acc_addr_q;
  logic [NUM_COLS-1:0] acc_wr_data_q, h_rd_data_q;
  logic              h_rd_valid_q;
  logic [XW-1:0]     x_q;
  logic [RW:0]       fifo_mem_q [RES_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     fifo_cnt_q, free_slots;
  logic              arb_ok, mac_elig, grant_host, grant_mac, push, pop, plane_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    n_eff = NUM_CFG_BITS'(RES_DEPTH) < n_input_bits_cfg ? CW'(RES_DEPTH) : CW'(n_input_bits_cfg);
    if (n_input_bits_cfg == '0) n_eff = CW'(1);
  end

  // Host wins a tie only when the round-robin pointer currently favours it.
  assign free_slots = CW'(RES_DEPTH) - fifo_cnt_q;
  assign arb_ok     = (state_q == ST_IDLE) || (state_q == ST_MAC_READY);
  assign mac_elig   = x_valid_i && (free_slots >= n_eff);
  assign grant_host = arb_ok && h_rq_valid_i && (!mac_elig || rr_host_q);
  assign grant_mac  = arb_ok && mac_elig && !grant_host;
  assign plane_last = (cnt_q == CNT_W'(n_q - 1'b1));
  assign push       = (state_q == ST_MAC_RUN);
  assign pop        = res_valid_o && res_ready_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_MAC_READY: begin
        if (grant_host)
          state_d = ST_SRAM_REQ;
        else if (grant_mac)
          state_d = (state_q == ST_IDLE && SETTLE_CYCLES > 0) ? ST_MAC_SETTLE : ST_MAC_RUN;
      end
      ST_SRAM_REQ:     if (acc_rq_ready_i) state_d = acc_rq_wr_q ? ST_IDLE : ST_SRAM_RD_WAIT;
      ST_SRAM_RD_WAIT: if (acc_rd_valid_i) state_d = ST_IDLE;
      ST_MAC_SETTLE:   if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_MAC_RUN;
      ST_MAC_RUN:      if (plane_last) state_d = ST_MAC_READY;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_mac_en_o   = (state_q == ST_MAC_SETTLE) || (state_q == ST_MAC_RUN) ||
                     (state_q == ST_MAC_READY);
    acc_rq_valid_o = (state_q == ST_SRAM_REQ);
    h_rq_ready_o   = (state_q == ST_SRAM_REQ) && acc_rq_ready_i;
    x_ready_o      = grant_mac;
    busy_o         = !arb_ok || (fifo_cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      n_q           <= '0;
      rr_host_q     <= 1'b1;
      acc_rq_wr_q   <= 1'b0;
      acc_addr_q    <= '0;
      acc_wr_data_q <= '0;
      h_rd_valid_q  <= 1'b0;
      h_rd_data_q   <= '0;
      x_q           <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      if (grant_host) begin
        acc_rq_wr_q   <= h_rq_wr_i;
        acc_addr_q    <= h_addr_i;
        acc_wr_data_q <= h_wr_data_i;
        rr_host_q     <= 1'b0;
      end
      if (grant_mac) begin
        x_q       <= x_data_i;
        n_q       <= n_eff;
        rr_host_q <= 1'b1;
      end
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == ST_MAC_SETTLE || state_q == ST_MAC_RUN)
        cnt_q <= cnt_q + 1'b1;
      h_rd_valid_q <= (state_q == ST_SRAM_RD_WAIT) && acc_rd_valid_i;
      if ((state_q == ST_SRAM_RD_WAIT) && acc_rd_valid_i)
        h_rd_data_q <= acc_rd_data_i;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; the output mux hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {plane_last, acc_adc_out_i};
  end

  assign res_valid_o   = (fifo_cnt_q != '0);
  assign res_data_o    = res_valid_o ? fifo_mem_q[rd_ptr_q][RW-1:0] : '0;
  assign res_last_o    = res_valid_o && fifo_mem_q[rd_ptr_q][RW];
  assign acc_rq_wr_o   = acc_rq_wr_q;
  assign acc_addr_o    = acc_addr_q;
  assign acc_wr_data_o = acc_wr_data_q;
  assign acc_x_data_o  = x_q;
  assign h_rd_valid_o  = h_rd_valid_q;
  assign h_rd_data_o   = h_rd_data_q;

endmodule

// File: tb/tb_qracc_mac_sched.sv
// tb/tb_qracc_mac_sched.sv - scoreboard bench for qracc_mac_sched
// ADC input is a function of a negedge cycle counter so sampled-plane timing shows up in the data.
module tb_qracc_mac_sched;
  localparam int SETTLE = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   n_input_bits_cfg;
  logic         h_rq_valid_i, h_rq_wr_i, h_rq_ready_o, h_rd_valid_o;
  logic [6:0]   h_addr_i, acc_addr_o;
  logic [31:0]  h_wr_data_i, h_rd_data_o, acc_wr_data_o, acc_rd_data_i;
  logic         x_valid_i, x_ready_o;
  logic [255:0] x_data_i, acc_x_data_o;
  logic         res_valid_o, res_ready_i, res_last_o;
  logic [127:0] res_data_o, acc_adc_out_i;
  logic         acc_rq_valid_o, acc_rq_wr_o, acc_rq_ready_i, acc_rd_valid_i;
  logic         acc_mac_en_o, busy_o;

  typedef struct packed {logic [127:0] data; logic last;} res_t;
  res_t        exp_res[$];
  logic [31:0] exp_rd[$];
  res_t        mon_e;
  logic [31:0] mon_rd;
  logic [31:0] sram [128];
  logic        rd_pend = 1'b0;
  logic [6:0]  rd_addr = '0;
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  logic        watch_mac = 1'b0, mac_dropped = 1'b0;

  qracc_mac_sched dut (
    .clk(clk), .rst(rst), .n_input_bits_cfg(n_input_bits_cfg),
    .h_rq_valid_i(h_rq_valid_i), .h_rq_ready_o(h_rq_ready_o), .h_rq_wr_i(h_rq_wr_i),
    .h_addr_i(h_addr_i), .h_wr_data_i(h_wr_data_i), .h_rd_valid_o(h_rd_valid_o),
    .h_rd_data_o(h_rd_data_o), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .x_data_i(x_data_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_last_o(res_last_o), .acc_rq_valid_o(acc_rq_valid_o),
    .acc_rq_wr_o(acc_rq_wr_o), .acc_addr_o(acc_addr_o), .acc_wr_data_o(acc_wr_data_o),
    .acc_rq_ready_i(acc_rq_ready_i), .acc_rd_valid_i(acc_rd_valid_i),
    .acc_rd_data_i(acc_rd_data_i), .acc_mac_en_o(acc_mac_en_o),
    .acc_x_data_o(acc_x_data_o), .acc_adc_out_i(acc_adc_out_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] adc_of(input int c);
    logic [31:0] v;
    v = 32'(c);
    return {v, ~v, v ^ 32'hA5A5_0F0F, v + 32'h1234_5678};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM side of seq_acc: always ready, read data returned the cycle after the handshake.
  always @(negedge clk) begin
    cyc = cyc + 1;
    acc_adc_out_i = adc_of(cyc);
    acc_rd_valid_i = 1'b0;
    if (rd_pend) begin
      acc_rd_valid_i = 1'b1;
      acc_rd_data_i  = sram[rd_addr];
      rd_pend        = 1'b0;
    end
    if (!rst && acc_rq_valid_o && acc_rq_ready_i) begin
      if (acc_rq_wr_o) sram[acc_addr_o] = acc_wr_data_o;
      else begin
        rd_pend = 1'b1;
        rd_addr = acc_addr_o;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (res_valid_o && res_ready_i) begin
        if (exp_res.size() == 0) check("res_unexpected", 1'b1, 1'b0);
        else begin
          mon_e = exp_res.pop_front();
          check("res_data", res_data_o, mon_e.data);
          check("res_last", res_last_o, mon_e.last);
        end
      end
      if (h_rd_valid_o) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 1'b1, 1'b0);
        else begin
          mon_rd = exp_rd.pop_front();
          check("h_rd_data", h_rd_data_o, mon_rd);
        end
      end
      if (watch_mac && !acc_mac_en_o) mac_dropped = 1'b1;
    end
  end

  task automatic send_job(input logic [255:0] xd, input logic [7:0] cfg, input int n_exp,
                          input bit cold, input bit push_exp, output int acc_cyc);
    int budget = 0;
    x_data_i = xd;
    n_input_bits_cfg = cfg;
    x_valid_i = 1'b1;
    #1;
    while (!x_ready_o && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!x_ready_o) begin
      check("x_accept_timeout", 1'b0, 1'b1);
      x_valid_i = 1'b0;
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc;
      check("mac_en_before_accept", acc_mac_en_o, cold ? 1'b0 : 1'b1);
      if (push_exp)
        for (int k = 0; k < n_exp; k++)
          exp_res.push_back('{adc_of(acc_cyc + (cold ? SETTLE + 1 : 1) + k), k == n_exp - 1});
      @(negedge clk);
      x_valid_i = 1'b0;
      n_input_bits_cfg = 8'd3;
      #1;
      check("mac_en_after_accept", acc_mac_en_o, 1'b1);
      check("acc_x_data", acc_x_data_o, xd);
    end
  endtask

  task automatic host_op(input bit wr, input logic [6:0] addr, input logic [31:0] data,
                         output int acc_cyc);
    int budget = 0;
    h_rq_wr_i = wr;
    h_addr_i = addr;
    h_wr_data_i = wr ? data : 32'h0;
    h_rq_valid_i = 1'b1;
    #1;
    while (!h_rq_ready_o && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!h_rq_ready_o) begin
      check("host_accept_timeout", 1'b0, 1'b1);
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc;
      check("mac_en_host", acc_mac_en_o, 1'b0);
      check("acc_addr", acc_addr_o, addr);
      if (wr) check("acc_wr_data", acc_wr_data_o, data);
      else    exp_rd.push_back(data);
      @(negedge clk);
    end
    h_rq_valid_i = 1'b0;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {acc_mac_en_o, res_valid_o, busy_o, x_ready_o, h_rq_ready_o,
           h_rd_valid_o, acc_rq_valid_o, acc_rq_wr_o, res_last_o}, 9'b0);
    check({tag, "_acc_x_data"}, acc_x_data_o, 256'b0);
    check({tag, "_res_data"}, res_data_o, 128'b0);
    check({tag, "_host_regs"}, {h_rd_data_o, acc_wr_data_o, acc_addr_o}, 71'b0);
  endtask

  int t, hc, xc, r, j1, j2, j3;

  initial begin
    for (int i = 0; i < 128; i++) sram[i] = 32'h0;
    rst = 1'b1; n_input_bits_cfg = 8'd1; acc_rq_ready_i = 1'b1;
    h_rq_valid_i = 1'b0; h_rq_wr_i = 1'b0; h_addr_i = '0; h_wr_data_i = '0;
    x_valid_i = 1'b0; x_data_i = '0; res_ready_i = 1'b1; acc_rd_data_i = '0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset_init");
    rst = 1'b0;

    host_op(1'b1, 7'd5, 32'hA5A5_A5A5, t);
    host_op(1'b0, 7'd5, 32'hA5A5_A5A5, t);
    repeat (4) @(negedge clk);

    send_job({8{32'h1111_2222}}, 8'd2, 2, 1'b1, 1'b1, t);
    repeat (10) @(negedge clk);

    watch_mac = 1'b1;
    send_job({8{32'h3333_4444}}, 8'd1, 1, 1'b0, 1'b1, t);
    send_job({8{32'h5555_6666}}, 8'd1, 1, 1'b0, 1'b1, t);
    repeat (3) @(negedge clk);
    watch_mac = 1'b0;
    check("mac_en_never_dropped", mac_dropped, 1'b0);

    send_job({8{32'h7777_8888}}, 8'd0, 1, 1'b0, 1'b1, t);
    send_job({8{32'h9999_AAAA}}, 8'd200, 8, 1'b0, 1'b1, t);
    repeat (14) @(negedge clk);

    res_ready_i = 1'b0;
    send_job({8{32'hBBBB_CCCC}}, 8'd4, 4, 1'b0, 1'b0, t);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset_midjob");
    rst = 1'b0;
    @(negedge clk);
    #1 check("res_valid_after_reset", res_valid_o, 1'b0);
    res_ready_i = 1'b1;

    fork
      host_op(1'b1, 7'd9, 32'h1357_9BDF, hc);
      send_job({8{32'hDDDD_EEEE}}, 8'd2, 2, 1'b1, 1'b1, xc);
    join
    check("tie1_host_first", hc < xc, 1'b1);
    repeat (10) @(negedge clk);

    fork
      host_op(1'b0, 7'd9, 32'h1357_9BDF, hc);
      send_job({8{32'h0F0F_F0F0}}, 8'd1, 1, 1'b1, 1'b1, xc);
    join
    check("tie2_host_first", hc < xc, 1'b1);
    repeat (10) @(negedge clk);

    host_op(1'b1, 7'd12, 32'hCAFE_F00D, t);
    fork
      host_op(1'b0, 7'd12, 32'hCAFE_F00D, hc);
      send_job({8{32'h2468_ACE0}}, 8'd1, 1, 1'b1, 1'b1, xc);
    join
    check("tie3_mac_first", xc < hc, 1'b1);
    repeat (6) @(negedge clk);

    res_ready_i = 1'b0;
    send_job({8{32'hAAAA_0001}}, 8'd4, 4, 1'b1, 1'b1, j1);
    send_job({8{32'hAAAA_0002}}, 8'd4, 4, 1'b0, 1'b1, j2);
    fork
      send_job({8{32'hAAAA_0003}}, 8'd4, 4, 1'b0, 1'b1, j3);
      begin
        repeat (10) @(negedge clk);
        res_ready_i = 1'b1;
        #1 r = cyc;
      end
    join
    check("bp_third_accept_cycle", 32'(j3), 32'(r + 4));
    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(exp_res.size() + exp_rd.size()), 32'd0);
    check("idle_at_end", busy_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
